// File: rtl/adder_pkg.sv
// Shared definitions for the wide-add sequencer: limb width and controller states.
package adder_pkg;

    localparam int LIMB_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/B64Bit_adder.sv
// 64-bit ripple-carry adder; one full-adder stage per bit, carry chained LSB to MSB.
module B64Bit_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic carry;

    // Ripple the carry through all 64 bit positions.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < 64; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide adder built by feeding one 64-bit limb per cycle through a single shared
// ripple adder, LSB limb first, with the carry held in a register between limbs.
module wide_add_sequencer
    import adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORDS*LIMB_W-1:0] a_in,
    input  logic [WORDS*LIMB_W-1:0] b_in,
    input  logic                    c_in,
    output logic                    busy,
    output logic                    done,
    output logic [WORDS*LIMB_W-1:0] sum_out,
    output logic                    c_out
);

    localparam int W     = WORDS * LIMB_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [IDX_W-1:0]  idx_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              carry_q;
    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] b_limb;
    logic [LIMB_W-1:0] adder_sum;
    logic              adder_cout;

    // Pick the operand limbs addressed by the current limb index.
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_limb = a_q[i*LIMB_W +: LIMB_W];
                b_limb = b_q[i*LIMB_W +: LIMB_W];
            end
        end
    end

    B64Bit_adder u_adder (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry_q),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // Next-state decode; a start is only accepted from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture on accept, then one limb result and carry written per RUN cycle;
    // the index parks on the last limb rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_out <= '0;
            c_out   <= 1'b0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
            sum_out <= '0;
            c_out   <= 1'b0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    sum_out[i*LIMB_W +: LIMB_W] <= adder_sum;
                end
            end
            carry_q <= adder_cout;
            if (idx_q == LAST_IDX) begin
                c_out <= adder_cout;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
